// File: rtl/vga_fetch_buffer.sv
// Double-banked line buffer serving VGA framebuffer reads, sharing one SRAM port with the CPU.
// state  | meaning
// S_IDLE | choose a buffer fill (demand first, then prefetch) or a pending CPU access
// S_FILL | read LINE_WORDS ascending words into the target bank
// S_CPU  | single CPU read/write on the SRAM port
module vga_fetch_buffer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          FRAME_WORDS = 384,
    parameter int          LINE_WORDS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  vga_state,
    input  logic        vga_data_en,
    input  logic [31:0] vga_word_address,
    input  logic [3:0]  vga_byte_select,
    output logic [31:0] vga_data,
    output logic        vga_busy,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_select,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        sram_read,
    output logic        sram_write,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic [3:0]  sram_byte_select,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ack
);
    localparam int LOG2 = $clog2(LINE_WORDS);
    localparam int IW = (LOG2 > 0) ? LOG2 : 1;
    localparam logic [31:0] FRAME_W32 = 32'(FRAME_WORDS);
    localparam logic [IW-1:0] IDX_LAST = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CPU} state_t;

    state_t        state_q;
    logic [31:0]   data_q [2][LINE_WORDS];
    logic [31:0]   tag_q [2];
    logic [1:0]    valid_q;
    logic          last_valid_q, last_bank_q;
    logic [31:0]   last_tag_q;
    logic          fill_bank_q, fill_demand_q, fill_abort_q;
    logic [31:0]   fill_tag_q;
    logic [IW-1:0] fill_idx_q;
    logic          sram_read_q, sram_write_q, cpu_ack_q;
    logic [31:0]   sram_address_q, sram_wdata_q, cpu_rdata_q;
    logic [3:0]    sram_byte_select_q;

    logic [31:0]   vga_offset, vga_group, pf_tag, cpu_offset, cpu_group;
    logic [IW-1:0] vga_idx, cpu_idx;
    logic [1:0]    hit;
    logic          vga_hit, hit_bank, free_bank, pf_cached, pf_need;
    logic          fill_need_d, fill_bank_d, fill_demand_d;
    logic [31:0]   fill_tag_d;
    logic          unused_vga_be;

    assign unused_vga_be = ^vga_byte_select;

    assign vga_offset = vga_word_address - BASE_ADDR;
    assign vga_group  = vga_offset >> LOG2;
    assign vga_idx    = vga_offset[IW-1:0];
    assign hit[0]     = valid_q[0] && (tag_q[0] == vga_group);
    assign hit[1]     = valid_q[1] && (tag_q[1] == vga_group);
    assign vga_hit    = |hit;
    assign hit_bank   = ~hit[0];
    assign vga_data   = vga_hit ? data_q[hit_bank][vga_idx] : 32'h0;
    assign vga_busy   = vga_data_en && !vga_hit;

    assign cpu_offset = sram_address_q - BASE_ADDR;
    assign cpu_group  = cpu_offset >> LOG2;
    assign cpu_idx    = cpu_offset[IW-1:0];

    assign free_bank = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : ~last_bank_q);
    assign pf_tag    = last_tag_q + 32'd1;
    assign pf_cached = (valid_q[0] && tag_q[0] == pf_tag) || (valid_q[1] && tag_q[1] == pf_tag);
    assign pf_need   = last_valid_q && ((pf_tag << LOG2) < FRAME_W32) && !pf_cached;

    // Only demand fills move the "last group" pointer; a prefetch must not chain another prefetch.
    always_comb begin
        fill_need_d   = 1'b0;
        fill_tag_d    = 32'h0;
        fill_bank_d   = 1'b0;
        fill_demand_d = 1'b0;
        if (vga_data_en && !vga_hit && vga_offset < FRAME_W32) begin
            fill_need_d   = 1'b1;
            fill_tag_d    = vga_group;
            fill_bank_d   = free_bank;
            fill_demand_d = 1'b1;
        end else if (vga_state == 2'd1 && valid_q == 2'b00) begin
            fill_need_d   = 1'b1;
            fill_bank_d   = free_bank;
            fill_demand_d = 1'b1;
        end else if (pf_need) begin
            fill_need_d   = 1'b1;
            fill_tag_d    = pf_tag;
            fill_bank_d   = ~last_bank_q;
        end
    end

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            for (int b = 0; b < 2; b++) begin
                tag_q[b] <= 32'h0;
                for (int w = 0; w < LINE_WORDS; w++) data_q[b][w] <= 32'h0;
            end
            valid_q            <= 2'b00;
            last_valid_q       <= 1'b0;
            last_bank_q        <= 1'b0;
            last_tag_q         <= 32'h0;
            fill_bank_q        <= 1'b0;
            fill_demand_q      <= 1'b0;
            fill_abort_q       <= 1'b0;
            fill_tag_q         <= 32'h0;
            fill_idx_q         <= '0;
            sram_read_q        <= 1'b0;
            sram_write_q       <= 1'b0;
            sram_address_q     <= 32'h0;
            sram_wdata_q       <= 32'h0;
            sram_byte_select_q <= 4'h0;
            cpu_ack_q          <= 1'b0;
            cpu_rdata_q        <= 32'h0;
        end else begin
            cpu_ack_q <= 1'b0;
            if (vga_data_en && vga_hit) begin
                last_valid_q <= 1'b1;
                last_bank_q  <= hit_bank;
                last_tag_q   <= vga_group;
            end
            case (state_q)
                S_IDLE: begin
                    if (fill_need_d && vga_state != 2'd0) begin
                        state_q              <= S_FILL;
                        valid_q[fill_bank_d] <= 1'b0;
                        fill_bank_q          <= fill_bank_d;
                        fill_tag_q           <= fill_tag_d;
                        fill_demand_q        <= fill_demand_d;
                        fill_abort_q         <= 1'b0;
                        fill_idx_q           <= '0;
                        sram_read_q          <= 1'b1;
                        sram_address_q       <= BASE_ADDR + (fill_tag_d << LOG2);
                        sram_byte_select_q   <= 4'hF;
                    end else if ((cpu_read || cpu_write) && !cpu_ack_q) begin
                        state_q            <= S_CPU;
                        sram_read_q        <= cpu_read;
                        sram_write_q       <= cpu_write;
                        sram_address_q     <= cpu_address;
                        sram_wdata_q       <= cpu_wdata;
                        sram_byte_select_q <= cpu_write ? cpu_byte_select : 4'hF;
                    end
                end
                S_FILL: begin
                    if (sram_ack) begin
                        if (fill_abort_q || vga_state == 2'd0) begin
                            sram_read_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            data_q[fill_bank_q][fill_idx_q] <= sram_rdata;
                            if (fill_idx_q == IDX_LAST) begin
                                valid_q[fill_bank_q] <= 1'b1;
                                tag_q[fill_bank_q]   <= fill_tag_q;
                                sram_read_q          <= 1'b0;
                                state_q              <= S_IDLE;
                                if (fill_demand_q) begin
                                    last_valid_q <= 1'b1;
                                    last_bank_q  <= fill_bank_q;
                                    last_tag_q   <= fill_tag_q;
                                end
                            end else begin
                                fill_idx_q     <= fill_idx_q + 1'b1;
                                sram_address_q <= sram_address_q + 32'd1;
                            end
                        end
                    end else if (vga_state == 2'd0) begin
                        fill_abort_q <= 1'b1;
                    end
                end
                S_CPU: begin
                    if (sram_ack) begin
                        sram_read_q  <= 1'b0;
                        sram_write_q <= 1'b0;
                        cpu_ack_q    <= 1'b1;
                        state_q      <= S_IDLE;
                        if (sram_read_q) cpu_rdata_q <= sram_rdata;
                        for (int b = 0; b < 2; b++) begin
                            if (sram_write_q && valid_q[b] && tag_q[b] == cpu_group)
                                data_q[b][cpu_idx] <= merge_bytes(data_q[b][cpu_idx], sram_wdata_q,
                                                                  sram_byte_select_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (vga_state == 2'd0) begin
                valid_q      <= 2'b00;
                last_valid_q <= 1'b0;
            end
        end
    end

    assign sram_read        = sram_read_q;
    assign sram_write       = sram_write_q;
    assign sram_address     = sram_address_q;
    assign sram_wdata       = sram_wdata_q;
    assign sram_byte_select = sram_byte_select_q;
    assign cpu_ack          = cpu_ack_q;
    assign cpu_rdata        = cpu_rdata_q;
endmodule

// File: tb/tb_vga_fetch_buffer.sv
// Bench for vga_fetch_buffer: behavioural SRAM with 1-cycle ack, scoreboarded VGA reads, CPU tasks.
module tb_vga_fetch_buffer;
    localparam logic [31:0] BASE = 32'h200;
    localparam int FW = 384;
    localparam int LW = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  vga_state = 2'd0;
    logic        vga_data_en = 1'b0;
    logic [31:0] vga_word_address = 32'h0;
    logic [3:0]  vga_byte_select = 4'hF;
    logic [31:0] vga_data;
    logic        vga_busy;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_address = 32'h0, cpu_wdata = 32'h0;
    logic [3:0]  cpu_byte_select = 4'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        sram_read, sram_write;
    logic [31:0] sram_address, sram_wdata;
    logic [3:0]  sram_byte_select;
    logic [31:0] sram_rdata;
    logic        sram_ack;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0, load_val = 32'h0;

    int n_checks = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic        exp_busy_q[$];
    logic [31:0] log_addr[$], log_wdata[$];
    logic        log_wr[$];
    logic [3:0]  log_bs[$];
    logic [31:0] mem [0:2047];

    vga_fetch_buffer #(.BASE_ADDR(BASE), .FRAME_WORDS(FW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .vga_state(vga_state), .vga_data_en(vga_data_en),
        .vga_word_address(vga_word_address), .vga_byte_select(vga_byte_select),
        .vga_data(vga_data), .vga_busy(vga_busy), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_byte_select(cpu_byte_select),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .sram_read(sram_read), .sram_write(sram_write),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_byte_select(sram_byte_select),
        .sram_rdata(sram_rdata), .sram_ack(sram_ack));

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // SRAM: acks the cycle after it sees a request; logs each access when accepted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ack   <= 1'b0;
            sram_rdata <= 32'h0;
            for (int i = 0; i < 2048; i++) mem[i] <= pattern(32'(i));
        end else begin
            if (load_en) mem[load_addr[10:0]] <= load_val;
            if ((sram_read || sram_write) && !sram_ack) begin
                sram_ack <= 1'b1;
                log_addr.push_back(sram_address);
                log_wr.push_back(sram_write);
                log_bs.push_back(sram_byte_select);
                log_wdata.push_back(sram_wdata);
                if (sram_write) begin
                    for (int k = 0; k < 4; k++)
                        if (sram_byte_select[k]) mem[sram_address[10:0]][8*k +: 8] <= sram_wdata[8*k +: 8];
                end else begin
                    sram_rdata <= mem[sram_address[10:0]];
                end
            end else begin
                sram_ack <= 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic vga_cycle(input logic en, input int off, output logic [31:0] d, output logic b);
        @(posedge clk); #1;
        vga_data_en = en;
        vga_word_address = BASE + 32'(off);
        @(negedge clk);
        d = vga_data;
        b = vga_busy;
    endtask

    task automatic wait_log(input int target, input int max_cycles, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(posedge clk); #1;
            if (log_addr.size() >= target) ok = 1'b1;
        end
    endtask

    // Drives immediately, waits for the ack, holds the request through the ack cycle, then counts extra acks.
    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, output logic [31:0] rd, output int acks);
        cpu_read = !wr; cpu_write = wr; cpu_address = addr; cpu_wdata = wd; cpu_byte_select = be;
        acks = 0;
        rd = 32'hDEAD_0000;
        for (int i = 0; i < 200 && acks == 0; i++) begin
            @(negedge clk);
            if (cpu_ack) begin acks = 1; rd = cpu_rdata; end
        end
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
        end
    endtask

    // Sweeps group g word by word, `reps` times, scoreboarding data and busy.
    task automatic sweep_group(input int g, input int reps, input string name);
        logic [31:0] d, ed;
        logic b, eb;
        for (int s = 0; s < reps; s++)
            for (int w = 0; w < LW; w++) begin
                exp_q.push_back(pattern(BASE + 32'(g * LW + w)));
                exp_busy_q.push_back(1'b0);
                vga_cycle(1'b1, g * LW + w, d, b);
                ed = exp_q.pop_front();
                eb = exp_busy_q.pop_front();
                n_checks++;
                if (d !== ed || b !== eb) begin
                    n_fail++;
                    $display("FAIL %s off=%0d: data=%h busy=%b, want data=%h busy=%b", name, g * LW + w, d, b, ed, eb);
                end
            end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        n_checks++;
        if ({sram_read, sram_write, sram_address, sram_wdata, sram_byte_select} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_sram: rd=%b wr=%b addr=%h wd=%h be=%h, want all 0",
                     sram_read, sram_write, sram_address, sram_wdata, sram_byte_select);
        end
        n_checks++;
        if ({cpu_ack, cpu_rdata, vga_data, vga_busy} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_out: ack=%b rdata=%h vdata=%h busy=%b, want all 0", cpu_ack, cpu_rdata, vga_data, vga_busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_startup_fill();
        int base;
        logic ok;
        logic [31:0] d, ed;
        logic b, eb;
        base = log_addr.size();
        vga_state = 2'd1;
        wait_log(base + 8, 60, ok);
        tick(10);
        n_checks++;
        if (log_addr.size() != base + 8) begin
            n_fail++;
            $display("FAIL startup_count: got %0d reads, want 8", log_addr.size() - base);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (base + k >= log_addr.size() || log_addr[base + k] !== BASE + 32'(k) || log_wr[base + k] !== 1'b0) begin
                n_fail++;
                $display("FAIL startup_order[%0d]: got %h, want read of %h", k,
                         (base + k < log_addr.size()) ? log_addr[base + k] : 32'hX, BASE + 32'(k));
            end
        end
        exp_q.push_back(pattern(BASE + 32'd2));
        exp_busy_q.push_back(1'b0);
        vga_cycle(1'b1, 2, d, b);
        ed = exp_q.pop_front();
        eb = exp_busy_q.pop_front();
        n_checks++;
        if (d !== ed || b !== eb) begin
            n_fail++;
            $display("FAIL startup_read: data=%h busy=%b, want data=%h busy=%b", d, b, ed, eb);
        end
    endtask

    task automatic test_steady_scan();
        int base;
        vga_state = 2'd2;
        base = log_addr.size();
        sweep_group(0, 4, "steady_g0");
        n_checks++;
        if (log_addr.size() != base) begin
            n_fail++;
            $display("FAIL steady_no_refetch: got %0d reads, want 0", log_addr.size() - base);
        end
        sweep_group(1, 4, "steady_g1");
        n_checks++;
        if (log_addr.size() != base + 4) begin
            n_fail++;
            $display("FAIL steady_prefetch_count: got %0d reads, want 4", log_addr.size() - base);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (base + k >= log_addr.size() || log_addr[base + k] !== BASE + 32'(8 + k)) begin
                n_fail++;
                $display("FAIL steady_prefetch[%0d]: got %h, want %h", k,
                         (base + k < log_addr.size()) ? log_addr[base + k] : 32'hX, BASE + 32'(8 + k));
            end
        end
    endtask

    task automatic test_frame_end();
        int base;
        logic [31:0] mx, d;
        logic b;
        base = log_addr.size();
        for (int g = 2; g < FW / LW; g++) sweep_group(g, 4, "frame_sweep");
        vga_data_en = 1'b0;
        tick(20);
        mx = 32'h0;
        for (int k = base; k < log_addr.size(); k++) if (log_addr[k] > mx) mx = log_addr[k];
        n_checks++;
        if (log_addr.size() - base != (FW / LW - 3) * LW) begin
            n_fail++;
            $display("FAIL frame_read_count: got %0d, want %0d", log_addr.size() - base, (FW / LW - 3) * LW);
        end
        n_checks++;
        if (mx !== BASE + 32'(FW - 1)) begin
            n_fail++;
            $display("FAIL frame_max_addr: got %h, want %h", mx, BASE + 32'(FW - 1));
        end
        vga_state = 2'd0;
        base = log_addr.size();
        vga_cycle(1'b1, FW - 4, d, b);
        n_checks++;
        if (d !== 32'h0 || b !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_invalidate: data=%h busy=%b, want data=0 busy=1", d, b);
        end
        vga_cycle(1'b0, 0, d, b);
        tick(10);
        n_checks++;
        if (log_addr.size() != base) begin
            n_fail++;
            $display("FAIL frame_no_fill_inactive: got %0d reads, want 0", log_addr.size() - base);
        end
    endtask

    task automatic test_cpu_contention();
        int base, acks;
        logic [31:0] rd;
        base = log_addr.size();
        @(negedge clk);
        vga_state = 2'd1;
        cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, acks);
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL contention_ack_count: got %0d, want 1", acks);
        end
        n_checks++;
        if (rd !== pattern(32'h100)) begin
            n_fail++;
            $display("FAIL contention_rdata: got %h, want %h", rd, pattern(32'h100));
        end
        n_checks++;
        if (log_addr.size() != base + 9) begin
            n_fail++;
            $display("FAIL contention_count: got %0d accesses, want 9", log_addr.size() - base);
        end
        for (int k = 0; k < 9; k++) begin
            logic [31:0] ea;
            ea = (k < 8) ? BASE + 32'(k) : 32'h100;
            n_checks++;
            if (base + k >= log_addr.size() || log_addr[base + k] !== ea || log_wr[base + k] !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_order[%0d]: got %h, want read of %h", k,
                         (base + k < log_addr.size()) ? log_addr[base + k] : 32'hX, ea);
            end
        end
    endtask

    task automatic test_coherence();
        int base, acks, n;
        logic ok, b, eb;
        logic [31:0] rd, d, ed;
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = BASE + 32'd1; load_val = 32'h1122_3344; vga_state = 2'd0;
        @(posedge clk); #1;
        load_en = 1'b0;
        base = log_addr.size();
        vga_state = 2'd1;
        wait_log(base + 8, 60, ok);
        tick(4);
        exp_q.push_back(32'h1122_3344);
        exp_busy_q.push_back(1'b0);
        vga_cycle(1'b1, 1, d, b);
        ed = exp_q.pop_front();
        eb = exp_busy_q.pop_front();
        n_checks++;
        if (d !== ed || b !== eb) begin
            n_fail++;
            $display("FAIL coherence_before: data=%h busy=%b, want data=%h busy=%b", d, b, ed, eb);
        end
        vga_data_en = 1'b0;
        cpu_access(1'b1, BASE + 32'd1, 32'hAABB_CCDD, 4'b0011, rd, acks);
        n = log_addr.size();
        n_checks++;
        if (acks != 1 || n == 0 || log_wr[n - 1] !== 1'b1 || log_bs[n - 1] !== 4'b0011 ||
            log_addr[n - 1] !== BASE + 32'd1 || log_wdata[n - 1] !== 32'hAABB_CCDD) begin
            n_fail++;
            $display("FAIL coherence_sram_write: acks=%0d last wr=%b be=%b addr=%h wd=%h, want 1 wr=1 be=0011 addr=%h wd=aabbccdd",
                     acks, (n > 0) ? log_wr[n - 1] : 1'bx, (n > 0) ? log_bs[n - 1] : 4'hx,
                     (n > 0) ? log_addr[n - 1] : 32'hx, (n > 0) ? log_wdata[n - 1] : 32'hx, BASE + 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back((k == 0) ? 32'h1122_CCDD : pattern(BASE));
            exp_busy_q.push_back(1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            vga_cycle(1'b1, 1 - k, d, b);
            ed = exp_q.pop_front();
            eb = exp_busy_q.pop_front();
            n_checks++;
            if (d !== ed || b !== eb) begin
                n_fail++;
                $display("FAIL coherence_after off=%0d: data=%h busy=%b, want data=%h busy=%b", 1 - k, d, b, ed, eb);
            end
        end
        vga_data_en = 1'b0;
    endtask

    task automatic test_inactive_abort();
        int base;
        logic ok, b;
        logic [31:0] d;
        vga_state = 2'd0;
        tick(2);
        base = log_addr.size();
        vga_state = 2'd1;
        wait_log(base + 2, 40, ok);
        vga_state = 2'd0;
        @(posedge clk); #1;
        vga_state = 2'd2;
        tick(10);
        n_checks++;
        if (!ok || log_addr.size() != base + 2 || sram_read !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reads: got %0d reads sram_read=%b, want 2 reads sram_read=0", log_addr.size() - base, sram_read);
        end
        vga_cycle(1'b1, 0, d, b);
        n_checks++;
        if (d !== 32'h0 || b !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_discard: data=%h busy=%b, want data=0 busy=1", d, b);
        end
        vga_data_en = 1'b0;
        tick(30);
    endtask

    task automatic test_async_reset();
        int base;
        logic ok;
        vga_state = 2'd0;
        tick(2);
        base = log_addr.size();
        vga_state = 2'd1;
        wait_log(base + 2, 40, ok);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (!ok || {sram_read, sram_write, sram_address, sram_wdata, sram_byte_select} !== 70'h0) begin
            n_fail++;
            $display("FAIL async_reset_sram: ok=%b rd=%b wr=%b addr=%h wd=%h be=%h, want all 0",
                     ok, sram_read, sram_write, sram_address, sram_wdata, sram_byte_select);
        end
        n_checks++;
        if ({cpu_ack, cpu_rdata, vga_data, vga_busy} !== 66'h0) begin
            n_fail++;
            $display("FAIL async_reset_out: ack=%b rdata=%h vdata=%h busy=%b, want all 0", cpu_ack, cpu_rdata, vga_data, vga_busy);
        end
        vga_state = 2'd0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup_fill();
        test_steady_scan();
        test_frame_end();
        test_cpu_contention();
        test_coherence();
        test_inactive_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
